ooops_cdb_arb: RTL and testbench
================================

Name: ooops_cdb_arb

Overview:
- Arbitrates the single common data bus (CDB) among NREQ functional-unit result producers; one result is broadcast per cycle.
- Broadcasts go to the reservation stations, the physical register file write port and the ROB completion logic.
- Round-robin fairness; registered output stage; branch-mispredict flush support.
- Sits between FU writeback stages and the CDB consumers in the OoOPs back end.

Parameters:
- NREQ, 4, number of requesting functional units (2..8).
- TW, 6, physical register tag width.
- DW, 32, result data width.
- MAXHOLD, 3, maximum consecutive priority grants to requester 0 while others wait (used only with the optional feature).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  mispredict flush; suppresses grants and broadcast this cycle.
- req_vld  in  NREQ  per-requester result valid.
- req_tag  in  NREQ*TW  per-requester destination tag; requester i occupies bits [i*TW +: TW].
- req_data  in  NREQ*DW  per-requester result; requester i occupies bits [i*DW +: DW].
- req_rdy  out  NREQ  one-hot grant; the result transfers when req_vld[i] & req_rdy[i].
- cdb_vld  out  1  registered broadcast valid.
- cdb_tag  out  TW  registered broadcast tag.
- cdb_data  out  DW  registered broadcast data.
- cdb_src  out  $clog2(NREQ)  registered index of the winning requester.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - cdb_vld=0, cdb_tag=0, cdb_data=0, cdb_src=0.
  - RR pointer ptr=0; hold counter=0.
  - req_rdy is combinational and is 0 while rst_n=0.
- Grant (combinational, same cycle):
  - The winner is the first i with req_vld[i]=1, searching ptr, ptr+1, ... modulo NREQ.
  - req_rdy = onehot(winner).
  - req_rdy = 0 if no requester is valid, or if flush=1.
  - req_rdy[i] never asserts without req_vld[i].
- Requester contract: a requester holds req_vld, req_tag and req_data stable until granted. The arbiter does not buffer ungranted requests.
- Output stage (1-cycle latency): on a clock edge with a grant, cdb_vld<=1 and cdb_tag, cdb_data, cdb_src <= the winner's fields.
- No grant (no request, or flush): cdb_vld<=0. cdb_tag, cdb_data and cdb_src hold their last values; they are don't-care when cdb_vld=0.
- CDB has no backpressure: every grant appears on the bus exactly one cycle later.
- Pointer update: after a grant to i, ptr <= (i+1) mod NREQ. With no grant, ptr holds. Wrap from NREQ-1 to 0.
- Flush:
  - flush=1 suppresses grants in that cycle.
  - A broadcast already registered (cdb_vld=1 during the flush cycle) still completes; consumers discard it by ROB age.
  - ptr is unchanged by flush.
- Simultaneous flush and rst_n=0: reset wins.
- Deassertion of rst_n mid-stream: the first possible grant is at the first clock edge after release, with ptr=0.
- Fairness guarantee: a continuously valid requester is granted within NREQ cycles.

Optional Feature:
- Macro: OOOPS_CDB_LDPRIO_EN.
- Enabled: requester 0 (load unit, which cannot stall on cache return) wins over the RR choice.
  - A hold counter increments on each requester-0 grant made while any other requester is valid.
  - When the counter reaches MAXHOLD, the next cycle grants by pure RR starting at ptr. This forced cycle excludes requester 0 if any other requester is valid.
  - The counter clears on that forced grant, on any cycle where requester 0 is not granted, and on reset.
  - ptr updates only on RR-chosen grants.
- Disabled: pure round-robin; the hold counter and MAXHOLD are unused and are not synthesized.

Decomposition:
- Shared package ooops_defs.v holds:
  - `OOOPS_PTAG_W (default for TW);
  - `OOOPS_XLEN (default for DW);
  - `OOOPS_NCDB (default for NREQ);
  - the macro OOOPS_CDB_LDPRIO_EN.
- One sub-module, ooops_rr_pick: a combinational rotate-priority picker.
  - Inputs: NREQ-wide request vector and ptr.
  - Outputs: one-hot grant, index, and any-grant signal.
  - Reusable by the issue-select logic.
- The top-level module holds the pointer, hold counter, output registers and data muxing.

Test Plan:
- Reset then idle: rst_n low 3 cycles, all req_vld=0 → cdb_vld=0 and req_rdy=0 throughout; ptr=0 after release.
- Single requester: req_vld=4'b0100, tag=6'h15, data=32'hDEADBEEF → req_rdy=4'b0100 the same cycle. Next cycle: cdb_vld=1, cdb_tag=6'h15, cdb_data=32'hDEADBEEF, cdb_src=2.
- All four requesting continuously from ptr=0 → grant order 0,1,2,3,0 on consecutive cycles, with cdb_src following one cycle later; no requester waits more than 4 cycles.
- Flush mid-stream: req_vld=4'b1010 with flush=1 for one cycle → req_rdy=0 that cycle, cdb_vld=0 next cycle, ptr unchanged. The following cycle grants requester 1 (with ptr=0).
- Async reset mid-broadcast: assert rst_n=0 between edges while cdb_vld=1 → cdb_vld drops to 0 immediately, without waiting for a clock edge.
- OOOPS_CDB_LDPRIO_EN with MAXHOLD=3 and req_vld=4'b0011 held → grants 0,0,0,1,0,0,0,1; same stimulus without the macro → 0,1,0,1,...

Source files
------------

// File: rtl/ooops_cdb_arb_pkg.sv
// rtl/ooops_cdb_arb_pkg.sv - shared defaults and helpers for the CDB arbiter
//
// Contents:
//   OOOPS_PTAG_W   default physical tag width (TW)
//   OOOPS_XLEN     default result data width (DW)
//   OOOPS_NCDB     default number of CDB requesters (NREQ)
//   OOOPS_MAXHOLD  default load-priority hold limit (MAXHOLD)
//   sel_w()        index width for an n-entry selector (at least 1 bit)
// Build option: define OOOPS_CDB_LDPRIO_EN to give requester 0 (load unit)
// bounded priority over the round-robin choice.
package ooops_cdb_arb_pkg;

    localparam int OOOPS_PTAG_W  = 6;
    localparam int OOOPS_XLEN    = 32;
    localparam int OOOPS_NCDB    = 4;
    localparam int OOOPS_MAXHOLD = 3;

    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ooops_rr_pick.sv
// rtl/ooops_rr_pick.sv - combinational rotate-priority (round-robin) picker
//
// Ports:
//   req  in  NREQ  request vector
//   ptr  in  SW    highest-priority position; search runs ptr, ptr+1, ... mod NREQ
//   gnt  out NREQ  one-hot grant (zero when no request)
//   idx  out SW    index of the granted request (zero when no request)
//   any  out 1     at least one request was granted
module ooops_rr_pick
    import ooops_cdb_arb_pkg::*;
#(
    parameter int NREQ = OOOPS_NCDB,
    parameter int SW   = sel_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [SW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [SW-1:0]   idx,
    output logic            any
);

    // Walk the search order backwards so the last hit written is the first
    // position at or after ptr; avoids a "found" flag breaking the loop.
    always_comb begin
        int j;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (req[j]) begin
                any = 1'b1;
                idx = SW'(j);
            end
        end
        if (any) begin
            gnt = NREQ'(1) << idx;
        end
    end

endmodule

// File: rtl/ooops_cdb_arb.sv
// rtl/ooops_cdb_arb.sv - common data bus arbiter with registered broadcast stage
//
// Ports:
//   clk       in  1        clock, rising edge
//   rst_n     in  1        asynchronous active-low reset
//   flush     in  1        mispredict flush; no grant and no new broadcast this cycle
//   req_vld   in  NREQ     per-requester result valid
//   req_tag   in  NREQ*TW  requester i at [i*TW +: TW]
//   req_data  in  NREQ*DW  requester i at [i*DW +: DW]
//   req_rdy   out NREQ     combinational one-hot grant
//   cdb_vld   out 1        registered broadcast valid
//   cdb_tag   out TW       registered broadcast tag
//   cdb_data  out DW       registered broadcast data
//   cdb_src   out SW       registered winning requester index
// Build option: OOOPS_CDB_LDPRIO_EN gives requester 0 priority, bounded by
// MAXHOLD consecutive wins while others wait; otherwise pure round-robin.
module ooops_cdb_arb
    import ooops_cdb_arb_pkg::*;
#(
    parameter int NREQ    = OOOPS_NCDB,
    parameter int TW      = OOOPS_PTAG_W,
    parameter int DW      = OOOPS_XLEN,
    parameter int MAXHOLD = OOOPS_MAXHOLD
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic [NREQ-1:0]      req_vld,
    input  logic [NREQ*TW-1:0]   req_tag,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_rdy,
    output logic                 cdb_vld,
    output logic [TW-1:0]        cdb_tag,
    output logic [DW-1:0]        cdb_data,
    output logic [sel_w(NREQ)-1:0] cdb_src
);

    localparam int SW = sel_w(NREQ);

    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("ooops_cdb_arb: NREQ must be 2..8");
    end
    if (MAXHOLD < 1) begin : g_bad_maxhold
        $error("ooops_cdb_arb: MAXHOLD must be at least 1");
    end

    logic [SW-1:0]   ptr;
    logic [NREQ-1:0] pick_req;
    logic [NREQ-1:0] pick_gnt;
    logic [SW-1:0]   pick_idx;
    logic            pick_any;

    logic [NREQ-1:0] win_gnt;
    logic [SW-1:0]   win_idx;
    logic            win_any;
    logic            rr_win;   // grant came from the round-robin picker

    ooops_rr_pick #(
        .NREQ (NREQ),
        .SW   (SW)
    ) u_pick (
        .req  (pick_req),
        .ptr  (ptr),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .any  (pick_any)
    );

`ifdef OOOPS_CDB_LDPRIO_EN
    localparam int HW = $clog2(MAXHOLD + 1);

    logic [HW-1:0] hold_cnt;
    logic          others_vld;
    logic          forced;
    logic          use_prio;

    assign others_vld = |req_vld[NREQ-1:1];
    assign forced     = (hold_cnt == HW'(MAXHOLD));
    assign use_prio   = !forced && req_vld[0];

    // The forced round-robin cycle must let someone other than the load
    // unit through, so mask requester 0 out whenever anybody else waits.
    always_comb begin
        pick_req = req_vld;
        if (forced && others_vld) begin
            pick_req[0] = 1'b0;
        end
    end

    always_comb begin
        win_gnt = pick_gnt;
        win_idx = pick_idx;
        win_any = pick_any;
        rr_win  = pick_any;
        if (use_prio) begin
            win_gnt = NREQ'(1);
            win_idx = '0;
            win_any = 1'b1;
            rr_win  = 1'b0;
        end
        if (flush) begin
            win_gnt = '0;
            win_any = 1'b0;
            rr_win  = 1'b0;
        end
    end

    // Counts priority wins taken at others' expense. A lone load-unit win
    // (nobody else waiting) leaves the count alone; any cycle without a
    // requester-0 grant, and the forced cycle itself, clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (forced || !(win_any && win_idx == '0)) begin
            hold_cnt <= '0;
        end else if (others_vld) begin
            hold_cnt <= hold_cnt + HW'(1);
        end
    end
`else
    assign pick_req = req_vld;

    always_comb begin
        win_gnt = pick_gnt;
        win_idx = pick_idx;
        win_any = pick_any;
        rr_win  = pick_any;
        if (flush) begin
            win_gnt = '0;
            win_any = 1'b0;
            rr_win  = 1'b0;
        end
    end
`endif

    assign req_rdy = win_gnt & {NREQ{rst_n}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (rr_win) begin
            ptr <= (win_idx == SW'(NREQ - 1)) ? '0 : win_idx + SW'(1);
        end
    end

    // Payload registers only load on a grant; they are don't-care while
    // cdb_vld is low, so holding them saves toggling on the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_vld  <= 1'b0;
            cdb_tag  <= '0;
            cdb_data <= '0;
            cdb_src  <= '0;
        end else begin
            cdb_vld <= win_any;
            if (win_any) begin
                cdb_tag  <= req_tag[win_idx*TW +: TW];
                cdb_data <= req_data[win_idx*DW +: DW];
                cdb_src  <= win_idx;
            end
        end
    end

endmodule

// File: tb/tb_ooops_cdb_arb.sv
// tb/tb_ooops_cdb_arb.sv - directed self-checking bench for ooops_cdb_arb
module tb_ooops_cdb_arb;

    localparam int NREQ    = 4;
    localparam int TW      = 6;
    localparam int DW      = 32;
    localparam int MAXHOLD = 3;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic [NREQ-1:0]   req_vld;
    logic [NREQ*TW-1:0] req_tag;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   req_rdy;
    logic              cdb_vld;
    logic [TW-1:0]     cdb_tag;
    logic [DW-1:0]     cdb_data;
    logic [1:0]        cdb_src;

    int n_checks;
    int n_fail;

    ooops_cdb_arb #(
        .NREQ    (NREQ),
        .TW      (TW),
        .DW      (DW),
        .MAXHOLD (MAXHOLD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .req_vld  (req_vld),
        .req_tag  (req_tag),
        .req_data (req_data),
        .req_rdy  (req_rdy),
        .cdb_vld  (cdb_vld),
        .cdb_tag  (cdb_tag),
        .cdb_data (cdb_data),
        .cdb_src  (cdb_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_req(input int i, input logic [TW-1:0] t, input logic [DW-1:0] d);
        req_tag[i*TW +: TW]  = t;
        req_data[i*DW +: DW] = d;
    endtask

    // Leaves the bench at a falling edge with reset released and ptr=0.
    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        flush   = 1'b0;
        req_vld = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        flush   = 1'b0;
        req_vld = '0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (cdb_vld !== 1'b0) begin
                n_fail++; $display("FAIL reset_cdb_vld: got %0b expected 0", cdb_vld);
            end
            n_checks++;
            if (req_rdy !== 4'b0000) begin
                n_fail++; $display("FAIL reset_req_rdy: got %b expected 0000", req_rdy);
            end
        end
        n_checks++;
        if (cdb_tag !== 6'h00 || cdb_data !== 32'h0 || cdb_src !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_payload: got tag=%h data=%h src=%0d expected 0/0/0", cdb_tag, cdb_data, cdb_src);
        end
        // Requests during reset must not be granted.
        @(negedge clk);
        req_vld = 4'b1111;
        flush   = 1'b1;
        #1;
        n_checks++;
        if (req_rdy !== 4'b0000) begin
            n_fail++; $display("FAIL reset_wins_rdy: got %b expected 0000", req_rdy);
        end
        @(posedge clk); #1;
        n_checks++;
        if (cdb_vld !== 1'b0) begin
            n_fail++; $display("FAIL reset_wins_vld: got %0b expected 0", cdb_vld);
        end
        @(negedge clk);
        req_vld = '0;
        flush   = 1'b0;
        rst_n   = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (cdb_vld !== 1'b0 || req_rdy !== 4'b0000) begin
                n_fail++; $display("FAIL idle_after_reset: got vld=%0b rdy=%b expected 0/0000", cdb_vld, req_rdy);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        set_req(2, 6'h15, 32'hDEADBEEF);
        req_vld = 4'b0100;
        #1;
        n_checks++;
        if (req_rdy !== 4'b0100) begin
            n_fail++; $display("FAIL single_rdy: got %b expected 0100", req_rdy);
        end
        @(posedge clk); #1;
        n_checks++;
        if (cdb_vld !== 1'b1 || cdb_tag !== 6'h15 || cdb_data !== 32'hDEADBEEF || cdb_src !== 2'd2) begin
            n_fail++;
            $display("FAIL single_cdb: got vld=%0b tag=%h data=%h src=%0d expected 1/15/deadbeef/2", cdb_vld, cdb_tag, cdb_data, cdb_src);
        end
        @(negedge clk);
        req_vld = '0;
        #1;
        n_checks++;
        if (req_rdy !== 4'b0000) begin
            n_fail++; $display("FAIL single_idle_rdy: got %b expected 0000", req_rdy);
        end
        @(posedge clk); #1;
        n_checks++;
        if (cdb_vld !== 1'b0) begin
            n_fail++; $display("FAIL single_idle_vld: got %0b expected 0", cdb_vld);
        end
    endtask

    task automatic test_rr_all();
        int exp_seq [5];
`ifdef OOOPS_CDB_LDPRIO_EN
        exp_seq = '{0, 0, 0, 1, 0};
`else
        exp_seq = '{0, 1, 2, 3, 0};
`endif
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, TW'(6'h10 + i), 32'hC0DE0000 + i);
        end
        req_vld = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++;
            if (req_rdy !== (4'b0001 << exp_seq[c])) begin
                n_fail++; $display("FAIL rr_all_rdy[%0d]: got %b expected grant to %0d", c, req_rdy, exp_seq[c]);
            end
            @(posedge clk); #1;
            n_checks++;
            if (cdb_vld !== 1'b1 || cdb_src !== 2'(exp_seq[c]) || cdb_tag !== TW'(6'h10 + exp_seq[c])
                || cdb_data !== 32'hC0DE0000 + exp_seq[c]) begin
                n_fail++;
                $display("FAIL rr_all_cdb[%0d]: got vld=%0b src=%0d tag=%h data=%h expected src %0d", c, cdb_vld, cdb_src, cdb_tag, cdb_data, exp_seq[c]);
            end
            @(negedge clk);
        end
        req_vld = '0;
    endtask

    task automatic test_two_req();
        int exp_seq [8];
`ifdef OOOPS_CDB_LDPRIO_EN
        exp_seq = '{0, 0, 0, 1, 0, 0, 0, 1};
`else
        exp_seq = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
        do_reset();
        set_req(0, 6'h2A, 32'h11110000);
        set_req(1, 6'h2B, 32'h22220001);
        req_vld = 4'b0011;
        for (int c = 0; c < 8; c++) begin
            #1;
            n_checks++;
            if (req_rdy !== (4'b0001 << exp_seq[c])) begin
                n_fail++; $display("FAIL two_req_rdy[%0d]: got %b expected grant to %0d", c, req_rdy, exp_seq[c]);
            end
            @(posedge clk); #1;
            n_checks++;
            if (cdb_vld !== 1'b1 || cdb_src !== 2'(exp_seq[c])) begin
                n_fail++; $display("FAIL two_req_cdb[%0d]: got vld=%0b src=%0d expected 1/%0d", c, cdb_vld, cdb_src, exp_seq[c]);
            end
            @(negedge clk);
        end
        req_vld = '0;
    endtask

    task automatic test_flush();
        do_reset();
        set_req(1, 6'h31, 32'hAAAA0001);
        set_req(3, 6'h33, 32'hAAAA0003);
        req_vld = 4'b1010;
        flush   = 1'b1;
        #1;
        n_checks++;
        if (req_rdy !== 4'b0000) begin
            n_fail++; $display("FAIL flush_rdy: got %b expected 0000", req_rdy);
        end
        @(posedge clk); #1;
        n_checks++;
        if (cdb_vld !== 1'b0) begin
            n_fail++; $display("FAIL flush_vld: got %0b expected 0", cdb_vld);
        end
        @(negedge clk);
        flush = 1'b0;
        #1;
        n_checks++;
        if (req_rdy !== 4'b0010) begin
            n_fail++; $display("FAIL flush_after_rdy: got %b expected 0010", req_rdy);
        end
        @(posedge clk); #1;
        n_checks++;
        if (cdb_vld !== 1'b1 || cdb_src !== 2'd1 || cdb_data !== 32'hAAAA0001) begin
            n_fail++; $display("FAIL flush_after_cdb: got vld=%0b src=%0d data=%h expected 1/1/aaaa0001", cdb_vld, cdb_src, cdb_data);
        end
        // ptr is now 2; a flush here must not move it, and the registered
        // broadcast of requester 1 is already on the bus this cycle.
        @(negedge clk);
        flush = 1'b1;
        #1;
        n_checks++;
        if (req_rdy !== 4'b0000 || cdb_vld !== 1'b1) begin
            n_fail++; $display("FAIL flush2: got rdy=%b vld=%0b expected 0000/1", req_rdy, cdb_vld);
        end
        @(posedge clk); #1;
        n_checks++;
        if (cdb_vld !== 1'b0) begin
            n_fail++; $display("FAIL flush2_vld: got %0b expected 0", cdb_vld);
        end
        @(negedge clk);
        flush = 1'b0;
        #1;
        n_checks++;
        if (req_rdy !== 4'b1000) begin
            n_fail++; $display("FAIL flush2_after_rdy: got %b expected 1000", req_rdy);
        end
        @(posedge clk); #1;
        n_checks++;
        if (cdb_vld !== 1'b1 || cdb_src !== 2'd3 || cdb_tag !== 6'h33) begin
            n_fail++; $display("FAIL flush2_after_cdb: got vld=%0b src=%0d tag=%h expected 1/3/33", cdb_vld, cdb_src, cdb_tag);
        end
        @(negedge clk);
        req_vld = '0;
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, TW'(6'h20 + i), 32'hBEEF0000 + i);
        end
        req_vld = 4'b1111;
        @(posedge clk); #1;
        n_checks++;
        if (cdb_vld !== 1'b1 || cdb_src !== 2'd0) begin
            n_fail++; $display("FAIL async_pre: got vld=%0b src=%0d expected 1/0", cdb_vld, cdb_src);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (cdb_vld !== 1'b0 || req_rdy !== 4'b0000) begin
            n_fail++; $display("FAIL async_drop: got vld=%0b rdy=%b expected 0/0000", cdb_vld, req_rdy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (req_rdy !== 4'b0001) begin
            n_fail++; $display("FAIL async_release_rdy: got %b expected 0001", req_rdy);
        end
        @(posedge clk); #1;
        n_checks++;
        if (cdb_vld !== 1'b1 || cdb_src !== 2'd0 || cdb_tag !== 6'h20) begin
            n_fail++; $display("FAIL async_release_cdb: got vld=%0b src=%0d tag=%h expected 1/0/20", cdb_vld, cdb_src, cdb_tag);
        end
        @(negedge clk);
        req_vld = '0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        flush    = 1'b0;
        req_vld  = '0;
        req_tag  = '0;
        req_data = '0;
        test_reset();
        test_single();
        test_rr_all();
        test_two_req();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
